// File: rtl/instruction_dispatch_queue.sv
// Program-memory instruction dispatcher: load in IDLE, stream slots out in RUN, stop at sentinel or last slot.
// Optional IDQ_WRAP_EN: program end wraps the fetch pointer to 0 and keeps dispatching, pulsing done.
module instruction_dispatch_queue #(
    parameter int DEPTH = 8,
    parameter int REG_W = 3,
    parameter int OP_W  = 3,
    parameter int IMM_W = 4,
    localparam int IW   = IMM_W + OP_W + 3 * REG_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [IW-1:0]    load_data,
    input  logic             start,
    input  logic             stall,
    output logic             valid,
    output logic [OP_W-1:0]  opcode,
    output logic [REG_W-1:0] RX,
    output logic [REG_W-1:0] RY,
    output logic [REG_W-1:0] RZ,
    output logic [IMM_W-1:0] immediate,
    output logic [AW-1:0]    pc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      mem_q [DEPTH];
    // MSB of the pointer flags "past the last slot", which ends the program like a sentinel
    logic [AW:0]        ptr_q;
    logic               valid_q;
    logic               done_q;
    logic [OP_W-1:0]    op_q;
    logic [REG_W-1:0]   rx_q;
    logic [REG_W-1:0]   ry_q;
    logic [REG_W-1:0]   rz_q;
    logic [IMM_W-1:0]   imm_q;
    logic [AW-1:0]      pc_q;

    logic [IW-1:0]      cur_word_s;
    logic               at_end_s;

    assign cur_word_s = mem_q[ptr_q[AW-1:0]];
    assign at_end_s   = ptr_q[AW] | (&cur_word_s);

    // Program memory is deliberately outside the reset domain so programs survive reset
    always_ff @(posedge clock) begin
        if (!reset && (state_q == IDLE) && load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Dispatch FSM with registered instruction fields
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= {(AW+1){1'b0}};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= {OP_W{1'b0}};
            rx_q    <= {REG_W{1'b0}};
            ry_q    <= {REG_W{1'b0}};
            rz_q    <= {REG_W{1'b0}};
            imm_q   <= {IMM_W{1'b0}};
            pc_q    <= {AW{1'b0}};
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        ptr_q   <= {(AW+1){1'b0}};
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (at_end_s) begin
`ifdef IDQ_WRAP_EN
                        ptr_q   <= {(AW+1){1'b0}};
                        done_q  <= 1'b1;
`else
                        state_q <= DONE;
                        done_q  <= 1'b1;
`endif
                    end else if (!stall) begin
                        imm_q   <= cur_word_s[IW-1 -: IMM_W];
                        op_q    <= cur_word_s[3*REG_W +: OP_W];
                        rx_q    <= cur_word_s[2*REG_W +: REG_W];
                        ry_q    <= cur_word_s[REG_W +: REG_W];
                        rz_q    <= cur_word_s[0 +: REG_W];
                        pc_q    <= ptr_q[AW-1:0];
                        valid_q <= 1'b1;
                        ptr_q   <= ptr_q + {{AW{1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign valid     = valid_q;
    assign done      = done_q;
    assign opcode    = op_q;
    assign RX        = rx_q;
    assign RY        = ry_q;
    assign RZ        = rz_q;
    assign immediate = imm_q;
    assign pc        = pc_q;

endmodule
